// File: rtl/scan_index_gen.sv
// Programmable scan sequencer producing the registered select index for a 3-to-8 decoder.
// Supports up-wrap, down-wrap, ping-pong and single-shot sweeps with a per-index dwell.
module scan_index_gen #(
  parameter int IDX_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [IDX_W-1:0]   limit,
  input  logic [DWELL_W-1:0] dwell,
  output logic [IDX_W-1:0]   idx,
  output logic               busy,
  output logic               step,
  output logic               done,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_ONCE = 2'b11;

  localparam logic [IDX_W-1:0]   IDX_ZERO = '0;
  localparam logic [IDX_W-1:0]   IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_d;
  logic               busy_d, step_d, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               dir_up_q, dir_up_d;
  logic [1:0]         mode_q, mode_d;
  logic [IDX_W-1:0]   limit_q, limit_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [IDX_W-1:0]   adv_idx;
  logic               adv_dir_up;

  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      step     <= 1'b0;
      done     <= 1'b0;
      cnt_q    <= '0;
      dir_up_q <= 1'b1;
      mode_q   <= MODE_UP;
      limit_q  <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx      <= idx_d;
      busy     <= busy_d;
      step     <= step_d;
      done     <= done_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
      mode_q   <= mode_d;
      limit_q  <= limit_d;
      dwell_q  <= dwell_d;
    end
  end

  // Index that would follow the current one if the dwell expired this cycle.
  always_comb begin
    adv_idx    = idx;
    adv_dir_up = dir_up_q;
    case (mode_q)
      MODE_UP, MODE_ONCE: begin
        adv_idx = (idx == limit_q) ? IDX_ZERO : idx + IDX_ONE;
      end
      MODE_DOWN: begin
        adv_idx = (idx == IDX_ZERO) ? limit_q : idx - IDX_ONE;
      end
      MODE_PING: begin
        if (limit_q == IDX_ZERO) begin
          adv_idx = IDX_ZERO;
        end else if (dir_up_q) begin
          if (idx == limit_q) begin
            adv_idx    = idx - IDX_ONE;
            adv_dir_up = 1'b0;
          end else begin
            adv_idx = idx + IDX_ONE;
          end
        end else begin
          if (idx == IDX_ZERO) begin
            adv_idx    = IDX_ONE;
            adv_dir_up = 1'b1;
          end else begin
            adv_idx = idx - IDX_ONE;
          end
        end
      end
      default: adv_idx = idx;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx;
    busy_d   = busy;
    step_d   = 1'b0;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    mode_d   = mode_q;
    limit_d  = limit_q;
    dwell_d  = dwell_q;
    case (state_q)
      IDLE: begin
        idx_d  = '0;
        busy_d = 1'b0;
        if (start) begin
          state_d  = SCAN;
          mode_d   = mode;
          limit_d  = limit;
          dwell_d  = dwell;
          busy_d   = 1'b1;
          idx_d    = (mode == MODE_DOWN) ? limit : IDX_ZERO;
          cnt_d    = '0;
          dir_up_d = 1'b1;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == dwell_q) begin
          cnt_d = '0;
          // Single-shot ends at the last index instead of wrapping.
          if (mode_q == MODE_ONCE && idx == limit_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            idx_d   = '0;
          end else begin
            idx_d    = adv_idx;
            dir_up_d = adv_dir_up;
            step_d   = (adv_idx != idx);
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_index_gen.sv
// Bench for scan_index_gen: expected output words {busy,step,done,idx} are queued as each
// scan is launched and compared against the DUT on every falling edge.
module tb_scan_index_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [2:0] limit;
  logic [7:0] dwell;
  logic [2:0] idx;
  logic       busy;
  logic       step;
  logic       done;
  logic [1:0] dbg_state;

  int n_checks;
  int n_fails;
  string cur_tag;
  logic [5:0] exp_q[$];

  scan_index_gen #(.IDX_W(3), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .limit(limit), .dwell(dwell), .idx(idx), .busy(busy), .step(step),
    .done(done), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got busy/step/done/idx=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
               tag, got[5], got[4], got[3], got[2:0], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  function automatic logic [5:0] w(input logic b, input logic s, input logic d, input int i);
    logic [2:0] iv;
    iv = i[2:0];
    return {b, s, d, iv};
  endfunction

  // Scoreboard: one expected word per falling edge while the queue holds entries.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(cur_tag, {busy, step, done, idx}, e);
      end
    end
  end

  // Drivers
  task automatic start_scan(input logic [1:0] m, input int l, input int d, input logic with_stop);
    mode  = m;
    limit = l[2:0];
    dwell = d[7:0];
    start = 1'b1;
    stop  = with_stop;
    @(posedge clk);
  endtask

  task automatic stop_after(input int n);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    repeat (n - 1) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 500;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    if (exp_q.size() > 0) begin
      check({cur_tag, "_timeout"}, 6'd0, 6'd1);
      exp_q.delete();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; limit = 3'd0; dwell = 8'd0;

    cur_tag = "reset";
    repeat (3) @(posedge clk);
    exp_q.push_back(w(0, 0, 0, 0));
    #1 rst = 1'b0;
    wait_drain();

    // Up-wrap, full range, no dwell.
    @(posedge clk); #1;
    cur_tag = "up_l7_d0";
    start_scan(2'b00, 7, 0, 1'b0);
    exp_q.push_back(w(1, 0, 0, 0));
    for (int i = 1; i <= 7; i++) exp_q.push_back(w(1, 1, 0, i));
    exp_q.push_back(w(1, 1, 0, 0));
    exp_q.push_back(w(1, 1, 0, 1));
    exp_q.push_back(w(0, 0, 0, 0));
    stop_after(10);
    wait_drain();

    // Down-wrap with dwell 2.
    @(posedge clk); #1;
    cur_tag = "down_l5_d2";
    start_scan(2'b01, 5, 2, 1'b0);
    for (int g = 0; g <= 5; g++)
      for (int k = 0; k < 3; k++)
        exp_q.push_back(w(1, (k == 0 && g > 0), 0, 5 - g));
    exp_q.push_back(w(1, 1, 0, 5));
    exp_q.push_back(w(0, 0, 0, 0));
    stop_after(19);
    wait_drain();

    // Ping-pong across 0..3.
    @(posedge clk); #1;
    cur_tag = "ping_l3_d0";
    start_scan(2'b10, 3, 0, 1'b0);
    begin
      int seq[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
      for (int i = 0; i < 8; i++) exp_q.push_back(w(1, (i > 0), 0, seq[i]));
    end
    exp_q.push_back(w(0, 0, 0, 0));
    stop_after(8);
    wait_drain();

    // Ping-pong with a single-entry range never steps.
    @(posedge clk); #1;
    cur_tag = "ping_l0_d1";
    start_scan(2'b10, 0, 1, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(w(1, 0, 0, 0));
    exp_q.push_back(w(0, 0, 0, 0));
    stop_after(4);
    wait_drain();

    // Single-shot; limit change and a second start mid-scan must be ignored.
    @(posedge clk); #1;
    cur_tag = "once_l2_d1";
    start_scan(2'b11, 2, 1, 1'b0);
    exp_q.push_back(w(1, 0, 0, 0));
    exp_q.push_back(w(1, 0, 0, 0));
    exp_q.push_back(w(1, 1, 0, 1));
    exp_q.push_back(w(1, 0, 0, 1));
    exp_q.push_back(w(1, 1, 0, 2));
    exp_q.push_back(w(1, 0, 0, 2));
    exp_q.push_back(w(0, 0, 1, 0));
    exp_q.push_back(w(0, 0, 0, 0));
    #1 start = 1'b0;
    @(posedge clk);
    #1 limit = 3'd7; mode = 2'b00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain();

    // Stop coinciding with the final single-shot expiry suppresses done.
    @(posedge clk); #1;
    cur_tag = "once_stop_final";
    start_scan(2'b11, 1, 0, 1'b0);
    exp_q.push_back(w(1, 0, 0, 0));
    exp_q.push_back(w(1, 1, 0, 1));
    exp_q.push_back(w(0, 0, 0, 0));
    exp_q.push_back(w(0, 0, 0, 0));
    stop_after(2);
    wait_drain();

    // Start and stop together in IDLE: the scan starts.
    @(posedge clk); #1;
    cur_tag = "start_with_stop";
    start_scan(2'b00, 2, 0, 1'b1);
    exp_q.push_back(w(1, 0, 0, 0));
    exp_q.push_back(w(1, 1, 0, 1));
    exp_q.push_back(w(1, 1, 0, 2));
    exp_q.push_back(w(1, 1, 0, 0));
    exp_q.push_back(w(0, 0, 0, 0));
    stop_after(4);
    wait_drain();

    // Reset asserted for two cycles in the middle of a scan.
    @(posedge clk); #1;
    cur_tag = "reset_mid_scan";
    start_scan(2'b00, 7, 0, 1'b0);
    exp_q.push_back(w(1, 0, 0, 0));
    exp_q.push_back(w(1, 1, 0, 1));
    exp_q.push_back(w(1, 1, 0, 2));
    exp_q.push_back(w(0, 0, 0, 0));
    exp_q.push_back(w(0, 0, 0, 0));
    exp_q.push_back(w(0, 0, 0, 0));
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_drain();

    // Random up-wrap runs with random range and dwell.
    for (int r = 0; r < 4; r++) begin
      int l, d, n, cur;
      l = $urandom_range(0, 7);
      d = $urandom_range(0, 3);
      n = (l + 1) * (d + 1) + $urandom_range(1, 4);
      @(posedge clk); #1;
      cur_tag = "rand_up";
      start_scan(2'b00, l, d, 1'b0);
      cur = 0;
      for (int c = 0; c < n; c++) begin
        logic s;
        s = 1'b0;
        if (c > 0 && (c % (d + 1)) == 0) begin
          int nxt;
          nxt = (cur == l) ? 0 : cur + 1;
          s = (nxt != cur);
          cur = nxt;
        end
        exp_q.push_back(w(1, s, 0, cur));
      end
      exp_q.push_back(w(0, 0, 0, 0));
      stop_after(n);
      wait_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
